countdown_timer_bcd: RTL and testbench

Parametrised BCD countdown timer: loads an N-digit minute value plus a two-digit seconds value, counts down once per internal 1 Hz-equivalent tick while enabled, and flags expiry and invalid loads. It replaces the fixed two-minute-digit timer at the top of the kitchen-timer design. It feeds the 7-segment display driver with a flat BCD digit bus and drives the done and error LEDs.

---
 rtl/countdown_timer_bcd.sv | 170 +++++++++++++++++
 tb/tb_countdown_timer_bcd.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_bcd.sv
// BCD countdown timer: N minute digits plus MM:SS seconds, one decrement per TICK_DIV cycles.
// Optional feature: define TIMER_AUTORELOAD_EN to reload the last valid value on expiry.
module countdown_timer_bcd #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int MIN_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      CE,
  input  logic [4*MIN_DIGITS-1:0]   min_bcd,
  input  logic [7:0]                sec_bcd,
  output logic [4*MIN_DIGITS+7:0]   count_bcd,
  output logic                      running,
  output logic                      done,
  output logic                      expired,
  output logic                      error
);

  localparam int CW   = 4*MIN_DIGITS + 8;
  localparam int NDIG = MIN_DIGITS + 2;
  localparam int TW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERROR} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            expired_q, expired_d;

  logic [CW-1:0]   load_val;
  logic [CW-1:0]   dec_val;
  logic [CW-1:0]   reload_val;
  logic            load_ok;
  logic            reload_ok;
  logic            tick;

  // Digit 1 (seconds tens) tops out at 5; every other digit at 9.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 1) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic bcd_valid(input logic [CW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > digit_max(i)) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef TIMER_AUTORELOAD_EN
  logic [CW-1:0] shadow_q, shadow_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (load && load_ok) shadow_d = load_val;
  end

  assign reload_val = shadow_q;
  assign reload_ok  = (shadow_q != '0);
`else
  assign reload_val = '0;
  assign reload_ok  = 1'b0;
`endif

  assign load_val = {min_bcd, sec_bcd};
  assign load_ok  = bcd_valid(load_val);
  assign dec_val  = bcd_dec(count_q);
  assign tick     = (state_q == S_RUN) && (tick_q == TICK_LAST);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tick_d    = tick_q;
    expired_d = 1'b0;

    if (load) begin
      tick_d = '0;
      if (load_ok) begin
        count_d = load_val;
        state_d = S_IDLE;
      end else begin
        count_d = '0;
        state_d = S_ERROR;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (CE) begin
            if (count_q != '0) begin
              state_d = S_RUN;
            end else if (reload_ok) begin
              count_d = reload_val;
              state_d = S_RUN;
            end else begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          tick_d = tick ? '0 : tick_q + TW'(1);
          if (!CE) state_d = S_IDLE;
          if (tick) begin
            if (count_q == CW'(1)) begin
              expired_d = 1'b1;
              if (reload_ok) begin
                count_d = reload_val;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
            end else begin
              count_d = dec_val;
            end
          end
        end
        default: ; // DONE and ERROR hold until load or reset
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      tick_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
    end
  end

  assign count_bcd = count_q;
  assign running   = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed self-checking bench for countdown_timer_bcd (TICK_DIV=4, MIN_DIGITS=2).
// Build with TIMER_AUTORELOAD_EN defined to exercise the reload variant.
module tb_countdown_timer_bcd;

  logic        clk;
  logic        reset;
  logic        load;
  logic        CE;
  logic [7:0]  min_bcd;
  logic [7:0]  sec_bcd;
  logic [15:0] count_bcd;
  logic        running;
  logic        done;
  logic        expired;
  logic        error;

  int checks;
  int failures;

  countdown_timer_bcd #(.TICK_DIV(4), .MIN_DIGITS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .CE        (CE),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .count_bcd (count_bcd),
    .running   (running),
    .done      (done),
    .expired   (expired),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    min_bcd = m;
    sec_bcd = s;
    load    = 1'b1;
    step(1);
    load    = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({count_bcd, running, done, expired, error} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got count=%h run=%b done=%b exp=%b err=%b, want all 0",
               count_bcd, running, done, expired, error);
    end
    reset = 1'b0;
    CE    = 1'b1;
    step(1);
    checks++;
    if (!(done === 1'b1 && expired === 1'b1 && running === 1'b0)) begin
      failures++;
      $display("FAIL idle_zero_ce: got done=%b exp=%b run=%b, want 1 1 0", done, expired, running);
    end
    CE = 1'b0;
    step(1);
    checks++;
    if (!(done === 1'b1 && expired === 1'b0)) begin
      failures++;
      $display("FAIL done_hold: got done=%b exp=%b, want 1 0", done, expired);
    end
  endtask

  task automatic test_countdown;
    do_load(8'h01, 8'h00);
    checks++;
    if (!(count_bcd === 16'h0100 && done === 1'b0 && running === 1'b0)) begin
      failures++;
      $display("FAIL load_0100: got count=%h done=%b run=%b, want 0100 0 0", count_bcd, done, running);
    end
    CE = 1'b1;
    step(1);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL run_entry: got running=%b, want 1", running);
    end
    step(3);
    checks++;
    if (count_bcd !== 16'h0100) begin
      failures++;
      $display("FAIL pre_first_tick: got %h, want 0100", count_bcd);
    end
    step(1);
    checks++;
    if (count_bcd !== 16'h0059) begin
      failures++;
      $display("FAIL first_tick: got %h, want 0059", count_bcd);
    end
    step(235);
    checks++;
    if (!(count_bcd === 16'h0001 && done === 1'b0 && expired === 1'b0)) begin
      failures++;
      $display("FAIL at_0001: got count=%h done=%b exp=%b, want 0001 0 0", count_bcd, done, expired);
    end
    step(1);
`ifdef TIMER_AUTORELOAD_EN
    checks++;
    if (!(count_bcd === 16'h0100 && done === 1'b0 && expired === 1'b1 && running === 1'b1)) begin
      failures++;
      $display("FAIL reload_0100: got count=%h done=%b exp=%b run=%b, want 0100 0 1 1",
               count_bcd, done, expired, running);
    end
    CE = 1'b0;
    step(1);
`else
    checks++;
    if (!(count_bcd === 16'h0000 && done === 1'b1 && expired === 1'b1 && running === 1'b0)) begin
      failures++;
      $display("FAIL expiry: got count=%h done=%b exp=%b run=%b, want 0000 1 1 0",
               count_bcd, done, expired, running);
    end
    step(1);
    checks++;
    if (!(expired === 1'b0 && done === 1'b1)) begin
      failures++;
      $display("FAIL expired_one_cycle: got exp=%b done=%b, want 0 1", expired, done);
    end
    step(5);
    checks++;
    if (!(done === 1'b1 && count_bcd === 16'h0000 && running === 1'b0)) begin
      failures++;
      $display("FAIL done_ignores_ce: got done=%b count=%h run=%b, want 1 0000 0", done, count_bcd, running);
    end
    CE = 1'b0;
`endif
  endtask

  task automatic test_borrow;
    CE = 1'b0;
    do_load(8'h10, 8'h00);
    CE = 1'b1;
    step(5);
    checks++;
    if (count_bcd !== 16'h0959) begin
      failures++;
      $display("FAIL borrow_1000: got %h, want 0959", count_bcd);
    end
    CE = 1'b0;
    do_load(8'h00, 8'h10);
    CE = 1'b1;
    step(5);
    checks++;
    if (count_bcd !== 16'h0009) begin
      failures++;
      $display("FAIL borrow_0010: got %h, want 0009", count_bcd);
    end
    CE = 1'b0;
  endtask

  task automatic test_error;
    do_load(8'h0A, 8'h00);
    checks++;
    if (!(error === 1'b1 && count_bcd === 16'h0000)) begin
      failures++;
      $display("FAIL err_min_0A: got err=%b count=%h, want 1 0000", error, count_bcd);
    end
    CE = 1'b1;
    step(3);
    checks++;
    if (!(error === 1'b1 && running === 1'b0 && done === 1'b0)) begin
      failures++;
      $display("FAIL err_ignores_ce: got err=%b run=%b done=%b, want 1 0 0", error, running, done);
    end
    CE = 1'b0;
    do_load(8'h00, 8'h05);
    do_load(8'h00, 8'h60);
    checks++;
    if (!(error === 1'b1 && count_bcd === 16'h0000)) begin
      failures++;
      $display("FAIL err_sec_60: got err=%b count=%h, want 1 0000", error, count_bcd);
    end
    do_load(8'h00, 8'h05);
    do_load(8'hA0, 8'h00);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL err_min_A0: got err=%b, want 1", error);
    end
    do_load(8'h00, 8'h05);
    do_load(8'h00, 8'h0A);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL err_sec_0A: got err=%b, want 1", error);
    end
    do_load(8'h00, 8'h05);
    checks++;
    if (!(error === 1'b0 && count_bcd === 16'h0005 && running === 1'b0 && done === 1'b0)) begin
      failures++;
      $display("FAIL err_exit: got err=%b count=%h run=%b done=%b, want 0 0005 0 0",
               error, count_bcd, running, done);
    end
  endtask

  task automatic test_pause;
    CE = 1'b0;
    do_load(8'h00, 8'h03);
    CE = 1'b1;
    step(6);
    checks++;
    if (count_bcd !== 16'h0002) begin
      failures++;
      $display("FAIL pause_pre: got %h, want 0002", count_bcd);
    end
    CE = 1'b0;
    step(10);
    checks++;
    if (!(count_bcd === 16'h0002 && running === 1'b0)) begin
      failures++;
      $display("FAIL pause_hold: got count=%h run=%b, want 0002 0", count_bcd, running);
    end
    CE = 1'b1;
    step(2);
    checks++;
    if (!(count_bcd === 16'h0002 && running === 1'b1)) begin
      failures++;
      $display("FAIL resume_early: got count=%h run=%b, want 0002 1", count_bcd, running);
    end
    step(1);
    checks++;
    if (count_bcd !== 16'h0001) begin
      failures++;
      $display("FAIL resume_tick: got %h, want 0001", count_bcd);
    end
    CE = 1'b0;
  endtask

  task automatic test_back_to_back;
    CE = 1'b0;
    do_load(8'h00, 8'h07);
    CE = 1'b1;
    step(4);
    min_bcd = 8'h00;
    sec_bcd = 8'h30;
    load    = 1'b1;
    step(1);
    load    = 1'b0;
    checks++;
    if (!(count_bcd === 16'h0030 && running === 1'b0)) begin
      failures++;
      $display("FAIL load_on_tick: got count=%h run=%b, want 0030 0", count_bcd, running);
    end
    step(1);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL run_after_load: got running=%b, want 1", running);
    end
    step(4);
    checks++;
    if (count_bcd !== 16'h0029) begin
      failures++;
      $display("FAIL tick_after_reload: got %h, want 0029", count_bcd);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({count_bcd, running, done, expired, error} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset: got count=%h run=%b done=%b exp=%b err=%b, want all 0",
               count_bcd, running, done, expired, error);
    end
    CE = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);
    checks++;
    if ({count_bcd, running, done, expired, error} !== 20'h0) begin
      failures++;
      $display("FAIL post_reset_idle: got count=%h run=%b done=%b exp=%b err=%b, want all 0",
               count_bcd, running, done, expired, error);
    end
  endtask

`ifdef TIMER_AUTORELOAD_EN
  task automatic test_autoreload;
    CE = 1'b0;
    do_load(8'h00, 8'h02);
    CE = 1'b1;
    step(5);
    checks++;
    if (count_bcd !== 16'h0001) begin
      failures++;
      $display("FAIL ar_0001: got %h, want 0001", count_bcd);
    end
    step(4);
    checks++;
    if (!(count_bcd === 16'h0002 && expired === 1'b1 && done === 1'b0 && running === 1'b1)) begin
      failures++;
      $display("FAIL ar_reload1: got count=%h exp=%b done=%b run=%b, want 0002 1 0 1",
               count_bcd, expired, done, running);
    end
    step(1);
    checks++;
    if (expired !== 1'b0) begin
      failures++;
      $display("FAIL ar_pulse_width: got exp=%b, want 0", expired);
    end
    step(7);
    checks++;
    if (!(count_bcd === 16'h0002 && expired === 1'b1 && running === 1'b1)) begin
      failures++;
      $display("FAIL ar_reload2: got count=%h exp=%b run=%b, want 0002 1 1", count_bcd, expired, running);
    end
    CE = 1'b0;
    step(1);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    load     = 1'b0;
    CE       = 1'b0;
    min_bcd  = 8'h00;
    sec_bcd  = 8'h00;
    step(2);
    test_reset;
    test_countdown;
    test_borrow;
    test_error;
    test_pause;
    test_back_to_back;
`ifdef TIMER_AUTORELOAD_EN
    test_autoreload;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
